// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample/slot widths, sample types and the slot-index to data-bit mapping.
// Used by both the transmitter and the receiver.
package i2s_pkg;

    localparam int I2S_WIDTH   = 24;
    localparam int SLOT_WIDTH  = 32;
    localparam int SLOT_IDX_W  = $clog2(SLOT_WIDTH);
    localparam int WORD_IDX_W  = $clog2(I2S_WIDTH);

    typedef logic signed [I2S_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    // Slot index 0 is the one-bit I2S delay, then MSB-first word bits, then zero padding.
    function automatic logic slotBit(input sample_t word, input logic [SLOT_IDX_W-1:0] k);
        int   kInt;
        logic bitVal;
        kInt   = int'(k);
        bitVal = 1'b0;
        if (kInt >= 1 && kInt <= I2S_WIDTH) begin
            bitVal = word[WORD_IDX_W'(I2S_WIDTH - kInt)];
        end
        return bitVal;
    endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake between the audio processor and the I2S transmitter.
interface i2s_transmitter_if;
    import i2s_pkg::*;

    sample_t s_left;
    sample_t s_right;
    logic    s_valid;
    logic    s_ready;

    modport master (
        output s_left,
        output s_right,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_left,
        input  s_right,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides sys_clk by BCLK_DIV into a registered bclk and a fall-tick strobe.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic bclk_o,
    output logic fallTick_o
);

    localparam int CNT_W = $clog2(BCLK_DIV);
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(BCLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] divCnt_q, divCnt_d;
    logic             bclk_q, bclk_d;
    logic             riseTick;

    assign riseTick   = (divCnt_q == RISE_AT);
    assign fallTick_o = (divCnt_q == FALL_AT);
    assign bclk_o     = bclk_q;

    always_comb begin
        divCnt_d = fallTick_o ? '0 : divCnt_q + 1'b1;
        bclk_d   = bclk_q;
        if (riseTick) begin
            bclk_d = 1'b1;
        end else if (fallTick_o) begin
            bclk_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            divCnt_q <= '0;
            bclk_q   <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            bclk_q   <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Stereo I2S master transmitter: one-pair input buffer, per-frame frame register, MSB-first serialiser.
// Build option I2S_TX_HOLD_LAST_EN: on underrun re-send the previous pair instead of silence.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    i2s_transmitter_if.slave   inBus,
    output logic               i2s_bclk,
    output logic               i2s_lrclk,
    output logic               i2s_data,
    output logic               frame_start,
    output logic               underrun
);

    localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(SLOT_WIDTH - 1);

    logic                  fallTick;
    logic [SLOT_IDX_W-1:0] bitIdx_q, bitIdx_d;
    logic                  lrclk_q, lrclk_d;
    logic                  data_q, data_d;
    stereo_t               buf_q, buf_d;
    logic                  bufFull_q, bufFull_d;
    stereo_t               frame_q, frame_d;
    logic                  frameStart_q, frameStart_d;
    logic                  underrun_q, underrun_d;
    logic                  frameTick;
    logic                  accept;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclkGen (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bclk_o     (i2s_bclk),
        .fallTick_o (fallTick)
    );

    assign accept        = inBus.s_valid && !bufFull_q;
    assign inBus.s_ready = ~bufFull_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_data      = data_q;
    assign frame_start   = frameStart_q;
    assign underrun      = underrun_q;

    // Slot counter, word select and data all move together on the bclk fall tick.
    always_comb begin
        bitIdx_d  = bitIdx_q;
        lrclk_d   = lrclk_q;
        data_d    = data_q;
        frameTick = 1'b0;
        if (fallTick) begin
            if (bitIdx_q == LAST_IDX) begin
                bitIdx_d  = '0;
                lrclk_d   = ~lrclk_q;
                frameTick = lrclk_q;
            end else begin
                bitIdx_d = bitIdx_q + 1'b1;
            end
            data_d = slotBit(lrclk_d ? frame_q.right : frame_q.left, bitIdx_d);
        end
    end

    // A frame start either consumes the buffered pair or underruns; accepts only land in an empty buffer.
    always_comb begin
        buf_d        = buf_q;
        bufFull_d    = bufFull_q;
        frame_d      = frame_q;
        frameStart_d = frameTick;
        underrun_d   = frameTick && !bufFull_q;
        if (frameTick && bufFull_q) begin
            frame_d   = buf_q;
            bufFull_d = 1'b0;
        end else begin
            if (frameTick) begin
`ifdef I2S_TX_HOLD_LAST_EN
                frame_d = frame_q;
`else
                frame_d = '0;
`endif
            end
            if (accept) begin
                buf_d     = {inBus.s_left, inBus.s_right};
                bufFull_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bitIdx_q     <= LAST_IDX;
            lrclk_q      <= 1'b1;
            data_q       <= 1'b0;
            buf_q        <= '0;
            bufFull_q    <= 1'b0;
            frame_q      <= '0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bitIdx_q     <= bitIdx_d;
            lrclk_q      <= lrclk_d;
            data_q       <= data_d;
            buf_q        <= buf_d;
            bufFull_q    <= bufFull_d;
            frame_q      <= frame_d;
            frameStart_q <= frameStart_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed self-checking bench for i2s_transmitter: reset, framing, handshake, underrun and extreme samples.
// Expected data for underrun frames follows I2S_TX_HOLD_LAST_EN when it is defined.
module tb_i2s_transmitter;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic i2s_bclk;
    logic i2s_lrclk;
    logic i2s_data;
    logic frame_start;
    logic underrun;

    int checks     = 0;
    int errors     = 0;
    int cycleCount = 0;

    logic [23:0] pairL [4];
    logic [23:0] pairR [4];
    int          acceptCycle [4];

    i2s_transmitter_if busIf ();

    i2s_transmitter #(
        .BCLK_DIV (8)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .inBus       (busIf.slave),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput(tag, {i2s_bclk, i2s_lrclk, i2s_data, busIf.s_ready, frame_start, underrun}, 64'b010100);
    endtask

    // Reset, then the first fall tick after release must open an underrunning left slot 8 cycles later.
    task automatic resetAndCheck(input string tag);
        int n;
        sys_rst = 1'b1;
        #1;
        checkResetValues({tag, "_rst_now"});
        step(3);
        checkResetValues({tag, "_rst_held"});
        sys_rst = 1'b0;
        for (n = 1; n <= 20; n++) begin
            step(1);
            if (frame_start === 1'b1) break;
        end
        checkOutput({tag, "_first_fs_delay"}, 64'(n), 64'd8);
        checkOutput({tag, "_first_fs_lrclk"}, 64'(i2s_lrclk), 64'd0);
        checkOutput({tag, "_first_fs_underrun"}, 64'(underrun), 64'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [23:0] l, input logic [23:0] r);
        logic wasReady;
        logic accepted;
        busIf.s_left  = l;
        busIf.s_right = r;
        busIf.s_valid = 1'b1;
        accepted      = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            wasReady = busIf.s_ready;
            @(posedge sys_clk);
            #1;
            if (wasReady === 1'b1) begin
                accepted = 1'b1;
                break;
            end
        end
        busIf.s_valid = 1'b0;
        checkOutput({tag, "_accepted"}, 64'(accepted), 64'd1);
        checkOutput({tag, "_ready_low"}, 64'(busIf.s_ready), 64'd0);
    endtask

    task automatic waitFrameStart(input string tag, input logic expUnderrun, output logic found);
        found = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step(1);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_fs_seen"}, 64'(found), 64'd1);
        if (found) begin
            checkOutput({tag, "_underrun"}, 64'(underrun), 64'(expUnderrun));
            checkOutput({tag, "_ready_at_fs"}, 64'(busIf.s_ready), 64'd1);
        end
    endtask

    // Samples i2s_data/lrclk on each bclk rise for one full frame and compares against the expected slots.
    task automatic captureFrame(input string tag, input logic expUnderrun,
                                input logic [23:0] expL, input logic [23:0] expR, input logic pulseCheck);
        logic        found;
        logic [63:0] dataBits;
        logic [63:0] lrBits;
        logic        prevB;
        int          n;
        int          startCycle;
        int          lrRise;
        waitFrameStart(tag, expUnderrun, found);
        if (!found) return;
        startCycle = cycleCount;
        prevB      = i2s_bclk;
        n          = 0;
        lrRise     = -1;
        dataBits   = '0;
        lrBits     = '0;
        for (int i = 0; i < 600 && n < 64; i++) begin
            step(1);
            if (i == 0 && pulseCheck) begin
                checkOutput({tag, "_ready_pulse_end"}, 64'(busIf.s_ready), 64'd0);
            end
            if (lrRise < 0 && i2s_lrclk === 1'b1) lrRise = cycleCount - startCycle;
            if (i2s_bclk === 1'b1 && prevB === 1'b0) begin
                dataBits[63-n] = i2s_data;
                lrBits[63-n]   = i2s_lrclk;
                n++;
            end
            prevB = i2s_bclk;
        end
        checkOutput({tag, "_rises"}, 64'(n), 64'd64);
        checkOutput({tag, "_data"}, dataBits, {1'b0, expL, 7'b0, 1'b0, expR, 7'b0});
        checkOutput({tag, "_lrclk"}, lrBits, {32'h0, 32'hFFFF_FFFF});
        checkOutput({tag, "_lr_half_period"}, 64'(lrRise), 64'd256);
    endtask

    initial begin
        logic        found;
        logic [23:0] holdL;
        logic [23:0] holdR;

        busIf.s_left  = '0;
        busIf.s_right = '0;
        busIf.s_valid = 1'b0;
        pairL = '{24'h123456, 24'hABCDEF, 24'h000001, 24'h7F00FF};
        pairR = '{24'h654321, 24'hFEDCBA, 24'h800001, 24'h00FF7F};

        // Power-on reset, then a second reset in the middle of the right slot.
        resetAndCheck("t0");
        step(300);
        checkOutput("t1_mid_right_slot", 64'(i2s_lrclk), 64'd1);
        resetAndCheck("t1");

        // Single pair, exact serial pattern.
        applyStimulus("t2", 24'hA55AF0, 24'h0FF033);
        captureFrame("t2_frame", 1'b0, 24'hA55AF0, 24'h0FF033, 1'b0);

        // Back-to-back pairs with s_valid held.
        waitFrameStart("t3_idle", 1'b1, found);
        fork
            begin
                logic wasReady;
                for (int p = 0; p < 4; p++) begin
                    busIf.s_left   = pairL[p];
                    busIf.s_right  = pairR[p];
                    busIf.s_valid  = 1'b1;
                    acceptCycle[p] = -1;
                    for (int i = 0; i < 2000; i++) begin
                        wasReady = busIf.s_ready;
                        @(posedge sys_clk);
                        #1;
                        if (wasReady === 1'b1) begin
                            acceptCycle[p] = cycleCount;
                            break;
                        end
                    end
                end
                busIf.s_valid = 1'b0;
            end
            begin
                captureFrame("t3_pair0", 1'b0, pairL[0], pairR[0], 1'b1);
                captureFrame("t3_pair1", 1'b0, pairL[1], pairR[1], 1'b1);
                captureFrame("t3_pair2", 1'b0, pairL[2], pairR[2], 1'b1);
                captureFrame("t3_pair3", 1'b0, pairL[3], pairR[3], 1'b0);
            end
        join
        checkOutput("t3_accept_gap_a", 64'(acceptCycle[2] - acceptCycle[1]), 64'd512);
        checkOutput("t3_accept_gap_b", 64'(acceptCycle[3] - acceptCycle[2]), 64'd512);

        // Starved input: two underrunning frames.
`ifdef I2S_TX_HOLD_LAST_EN
        holdL = pairL[3];
        holdR = pairR[3];
`else
        holdL = 24'h0;
        holdR = 24'h0;
`endif
        captureFrame("t4_underrun_a", 1'b1, holdL, holdR, 1'b0);
        captureFrame("t4_underrun_b", 1'b1, holdL, holdR, 1'b0);

        // Full-scale extremes.
        applyStimulus("t5", 24'h800000, 24'h7FFFFF);
        captureFrame("t5_frame", 1'b0, 24'h800000, 24'h7FFFFF, 1'b0);

        // Reset with a pair buffered: the pair is discarded, then a new pair goes out intact.
        waitFrameStart("t6_idle", 1'b1, found);
        applyStimulus("t6_discard", 24'h111111, 24'h222222);
        step(20);
        resetAndCheck("t6");
        applyStimulus("t6_new", 24'hC3A5E1, 24'h1E5A3C);
        captureFrame("t6_frame", 1'b0, 24'hC3A5E1, 24'h1E5A3C, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
